// File: rtl/gpio_irq_ctrl.sv
// GPIO input-event controller: sync, debounce, edge detect, pending
// latch and a single level interrupt, behind a small register slave.
`timescale 1ns/1ps
module gpio_irq_ctrl #(
   parameter int WIDTH         = 20,
   parameter int DEBOUNCE_TICK = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      address,
   input  logic [31:0]      write_data,
   output logic [31:0]      read_data,
   output logic             response,
   input  logic [WIDTH-1:0] gpio_in,
   output logic             irq
);

   localparam int CW = (DEBOUNCE_TICK > 1) ? $clog2(DEBOUNCE_TICK) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_TICK - 1);

   typedef enum logic [1:0] {
      REG_RISE_EN = 2'b00,
      REG_FALL_EN = 2'b01,
      REG_PENDING = 2'b10,
      REG_LEVEL   = 2'b11
   } reg_sel_t;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] sample_prev;
   logic [WIDTH-1:0] filtered;
   logic [WIDTH-1:0] filtered_d;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] pending;
   logic [CW-1:0]    tick_cnt;
   logic             tick;

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] event_hit;
   logic [WIDTH-1:0] w1c_mask;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rd_mux;
   logic             wr_rise;
   logic             wr_fall;
   logic             wr_pend;
   reg_sel_t         sel;
   logic             unused_bits;

   assign sel   = reg_sel_t'(address[3:2]);
   assign wdata = write_data[WIDTH-1:0];

   assign wr_rise = write & (sel == REG_RISE_EN);
   assign wr_fall = write & (sel == REG_FALL_EN);
   assign wr_pend = write & (sel == REG_PENDING);

   assign tick = (tick_cnt == TICK_LAST);

   assign rise      = filtered & ~filtered_d;
   assign fall      = ~filtered & filtered_d;
   assign event_hit = (rise & rise_en) | (fall & fall_en);
   assign w1c_mask  = wr_pend ? wdata : '0;

   assign response    = read | write;
   assign unused_bits = ^{address[31:4], address[1:0], write_data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // A pin only moves filtered after two consecutive tick samples agree.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_prev <= '0;
         filtered    <= '0;
      end else if (tick) begin
         sample_prev <= sync2;
         filtered    <= (sync2 & ~(sync2 ^ sample_prev))
                      | (filtered & (sync2 ^ sample_prev));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filtered_d <= '0;
      end else begin
         filtered_d <= filtered;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_en <= '0;
         fall_en <= '0;
      end else begin
         if (wr_rise) rise_en <= wdata;
         if (wr_fall) fall_en <= wdata;
      end
   end

   // A fresh event beats a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         irq     <= 1'b0;
      end else begin
         pending <= event_hit | (pending & ~w1c_mask);
         irq     <= |pending;
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (sel)
         REG_RISE_EN: rd_mux = rise_en;
         REG_FALL_EN: rd_mux = fall_en;
         REG_PENDING: rd_mux = pending;
         REG_LEVEL:   rd_mux = filtered;
         default:     rd_mux = '0;
      endcase
   end

   always_comb begin
      read_data = '0;
      if (read) read_data[WIDTH-1:0] = rd_mux;
   end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: one instance with DEBOUNCE_TICK=1,
// one with DEBOUNCE_TICK=4, shared clock, reset and address/data.
`timescale 1ns/1ps
module tb_gpio_irq_ctrl;

   localparam int W = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        rd1, wr1, rd4, wr4;
   logic [31:0] rdata1, rdata4;
   logic        resp1, resp4;
   logic        irq1, irq4;
   logic [W-1:0] g1, g4;

   int checks = 0;
   int errors = 0;

   logic [31:0] d;
   logic        r;

   always #5 clk = ~clk;

   gpio_irq_ctrl #(.WIDTH(W), .DEBOUNCE_TICK(1)) dut1 (
      .clk(clk), .reset(reset), .read(rd1), .write(wr1),
      .address(address), .write_data(write_data),
      .read_data(rdata1), .response(resp1),
      .gpio_in(g1), .irq(irq1)
   );

   gpio_irq_ctrl #(.WIDTH(W), .DEBOUNCE_TICK(4)) dut4 (
      .clk(clk), .reset(reset), .read(rd4), .write(wr4),
      .address(address), .write_data(write_data),
      .read_data(rdata4), .response(resp4),
      .gpio_in(g4), .irq(irq4)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Write spans exactly one rising edge; call at posedge+1.
   task automatic wr(input bit which, input logic [1:0] a,
                     input logic [31:0] v);
      address    = {28'd0, a, 2'b00};
      write_data = v;
      if (which) wr4 = 1'b1; else wr1 = 1'b1;
      @(posedge clk);
      #1;
      wr1 = 1'b0;
      wr4 = 1'b0;
   endtask

   task automatic rd(input bit which, input logic [1:0] a,
                     output logic [31:0] v, output logic rsp);
      address = {28'd0, a, 2'b00};
      if (which) rd4 = 1'b1; else rd1 = 1'b1;
      #1;
      v   = which ? rdata4 : rdata1;
      rsp = which ? resp4 : resp1;
      rd1 = 1'b0;
      rd4 = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      rd1 = 1'b0; wr1 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
      address = '0; write_data = '0;
      g1 = '0; g4 = '0;
      step(2);
      check("idle_rdata", rdata1, 32'h0);
      reset = 1'b0;
      step(1);

      for (int a = 0; a < 4; a++) begin
         rd(1'b0, a[1:0], d, r);
         check($sformatf("rst_reg%0d", a), d, 32'h0);
         check($sformatf("rst_resp%0d", a), {31'd0, r}, 32'h1);
      end
      check("rst_irq1", {31'd0, irq1}, 32'h0);
      check("rst_irq4", {31'd0, irq4}, 32'h0);

      // Rise on pin 0 with one-cycle tick: level at 4, pending 5, irq 6.
      wr(1'b0, 2'd0, 32'h1);
      g1[0] = 1'b1;
      step(4);
      rd(1'b0, 2'd3, d, r); check("lat_level4", d, 32'h1);
      rd(1'b0, 2'd2, d, r); check("lat_pend4", d, 32'h0);
      step(1);
      rd(1'b0, 2'd2, d, r); check("lat_pend5", d, 32'h1);
      check("lat_irq5", {31'd0, irq1}, 32'h0);
      step(1);
      check("lat_irq6", {31'd0, irq1}, 32'h1);

      wr(1'b0, 2'd2, 32'h1);
      rd(1'b0, 2'd2, d, r); check("w1c_pend", d, 32'h0);
      check("w1c_irq_lag", {31'd0, irq1}, 32'h1);
      step(1);
      check("w1c_irq", {31'd0, irq1}, 32'h0);

      wr(1'b0, 2'd0, 32'hFFFF_FFFF);
      rd(1'b0, 2'd0, d, r); check("rise_en_mask", d, 32'h000F_FFFF);
      wr(1'b0, 2'd3, 32'hFFFF_FFFF);
      rd(1'b0, 2'd3, d, r); check("level_ro", d, 32'h1);

      // Simultaneous read and write returns the old value.
      address    = 32'h0;
      write_data = 32'h9;
      rd1 = 1'b1; wr1 = 1'b1;
      #1;
      check("rw_old", rdata1, 32'h000F_FFFF);
      @(posedge clk); #1;
      check("rw_new", rdata1, 32'h9);
      rd1 = 1'b0; wr1 = 1'b0;

      g1[3] = 1'b1;
      step(6);
      rd(1'b0, 2'd2, d, r); check("p3_set", d, 32'h8);
      check("p3_irq", {31'd0, irq1}, 32'h1);
      g1[3] = 1'b0;
      step(8);
      rd(1'b0, 2'd2, d, r); check("p3_fall_noen", d, 32'h8);

      // New rise lands on the same edge as a W1C of bit 3.
      g1[3] = 1'b1;
      step(4);
      wr(1'b0, 2'd2, 32'h8);
      rd(1'b0, 2'd2, d, r); check("collide_pend", d, 32'h8);
      check("collide_irq", {31'd0, irq1}, 32'h1);
      step(1);
      check("collide_irq2", {31'd0, irq1}, 32'h1);

      // Debounce with a four-cycle tick.
      wr(1'b1, 2'd1, 32'h8_0000);
      g4[19] = 1'b1;
      step(20);
      rd(1'b1, 2'd3, d, r); check("db_level_hi", d, 32'h8_0000);
      rd(1'b1, 2'd2, d, r); check("db_pend_init", d, 32'h0);
      g4[19] = 1'b0;
      step(2);
      g4[19] = 1'b1;
      step(20);
      rd(1'b1, 2'd3, d, r); check("glitch_level", d, 32'h8_0000);
      rd(1'b1, 2'd2, d, r); check("glitch_pend", d, 32'h0);
      check("glitch_irq", {31'd0, irq4}, 32'h0);
      g4[19] = 1'b0;
      step(12);
      rd(1'b1, 2'd2, d, r); check("fall_pend", d, 32'h8_0000);
      rd(1'b1, 2'd3, d, r); check("fall_level", d, 32'h0);
      step(1);
      check("fall_irq", {31'd0, irq4}, 32'h1);

      // Asynchronous reset between edges.
      check("pre_rst_irq", {31'd0, irq1}, 32'h1);
      #2 reset = 1'b1;
      #1;
      check("arst_irq1", {31'd0, irq1}, 32'h0);
      check("arst_irq4", {31'd0, irq4}, 32'h0);
      for (int a = 0; a < 4; a++) begin
         rd(1'b0, a[1:0], d, r);
         check($sformatf("arst_reg%0d", a), d, 32'h0);
      end
      step(2);
      reset = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
